hex7seg_to_byte: RTL and testbench

Receive-side counterpart of the byte-to-7-segment encoder: it samples the two 8-bit digit patterns `d1`/`d0` (segments a–g plus dp), waits until both are stable, decodes them back to a hex byte and hands the byte out over a valid/ready interface. It sits at the far end of a 7-segment display bus, for loopback checking of the encoder and for scraping display outputs in system tests. Invalid glyphs are flagged, never decoded.

---
 rtl/hex7seg_to_byte.sv | 132 +++++++++++++
 tb/tb_hex7seg_to_byte.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hex7seg_to_byte.sv
// hex7seg_to_byte: samples two 7-segment digit patterns, waits for them to
// settle, decodes them back to a hex byte and offers it on a valid/ready port.
// Invalid glyphs raise a one-cycle seg_err instead of producing a byte.
module hex7seg_to_byte #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:7] d1,
  input  logic [0:7] d0,
  output logic [7:0] a,
  output logic       a_valid,
  input  logic       a_ready,
  output logic [1:0] dp,
  output logic       seg_err,
  output logic       overrun
);

  typedef enum logic {SETTLE, HELD} state_t;

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  // Segment pattern (MSB = seg a ... LSB = seg g) to {valid, nibble}.
  function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: glyph_decode = 5'h10;
      7'b0110000: glyph_decode = 5'h11;
      7'b1101101: glyph_decode = 5'h12;
      7'b1111001: glyph_decode = 5'h13;
      7'b0110011: glyph_decode = 5'h14;
      7'b1011011: glyph_decode = 5'h15;
      7'b1011111: glyph_decode = 5'h16;
      7'b1110000: glyph_decode = 5'h17;
      7'b1111111: glyph_decode = 5'h18;
      7'b1111011: glyph_decode = 5'h19;
      7'b1110111: glyph_decode = 5'h1A;
      7'b0011111: glyph_decode = 5'h1B;
      7'b1001110: glyph_decode = 5'h1C;
      7'b0111101: glyph_decode = 5'h1D;
      7'b1001111: glyph_decode = 5'h1E;
      7'b1000111: glyph_decode = 5'h1F;
      default:    glyph_decode = 5'h00;
    endcase
  endfunction

  logic [0:7] d1_q, d0_q, snap1_q, snap0_q;
  logic [0:7] snap1_d, snap0_d;
  logic [7:0] cnt_q, cnt_d;
  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [1:0] dp_q, dp_d;
  logic       a_valid_q, a_valid_d;
  logic       seg_err_q, seg_err_d;
  logic       overrun_q, overrun_d;

  logic       changed, eval, load, both_blank;
  logic [4:0] dec1, dec0;

  // Stability tracking, one-shot evaluation and output handshake.
  always_comb begin
    changed    = {d1_q, d0_q} != {snap1_q, snap0_q};
    dec1       = glyph_decode(snap1_q[0:6]);
    dec0       = glyph_decode(snap0_q[0:6]);
    both_blank = (snap1_q[0:6] == 7'd0) && (snap0_q[0:6] == 7'd0);
    eval       = (state_q == SETTLE) && !changed && (cnt_q == STABLE_N);
    load       = eval && dec1[4] && dec0[4];

    snap1_d = snap1_q;
    snap0_d = snap0_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (changed) begin
      // The edge that sees the new value counts as its first sample.
      snap1_d = d1_q;
      snap0_d = d0_q;
      cnt_d   = 8'd1;
      state_d = SETTLE;
    end else if (state_q == SETTLE) begin
      if (cnt_q == STABLE_N) state_d = HELD;
      else                   cnt_d   = cnt_q + 8'd1;
    end

    a_d       = a_q;
    dp_d      = dp_q;
    a_valid_d = a_valid_q;
    overrun_d = overrun_q;
    if (a_valid_q && a_ready) a_valid_d = 1'b0;
    if (load) begin
      a_d       = {dec1[3:0], dec0[3:0]};
      dp_d      = {snap1_q[7], snap0_q[7]};
      a_valid_d = 1'b1;
      if (a_valid_q && !a_ready) overrun_d = 1'b1;
    end
    seg_err_d = eval && !load && !both_blank;
  end

  // State and output registers; reset discards everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q      <= '0;
      d0_q      <= '0;
      snap1_q   <= '0;
      snap0_q   <= '0;
      cnt_q     <= '0;
      state_q   <= SETTLE;
      a_q       <= '0;
      dp_q      <= '0;
      a_valid_q <= 1'b0;
      seg_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      d1_q      <= d1;
      d0_q      <= d0;
      snap1_q   <= snap1_d;
      snap0_q   <= snap0_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      a_q       <= a_d;
      dp_q      <= dp_d;
      a_valid_q <= a_valid_d;
      seg_err_q <= seg_err_d;
      overrun_q <= overrun_d;
    end
  end

  assign a       = a_q;
  assign dp      = dp_q;
  assign a_valid = a_valid_q;
  assign seg_err = seg_err_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_hex7seg_to_byte.sv
// Directed bench for hex7seg_to_byte (STABLE_CYCLES = 4).
module tb_hex7seg_to_byte;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:7] d1, d0;
  logic [7:0] a;
  logic       a_valid, a_ready;
  logic [1:0] dp;
  logic       seg_err, overrun;

  int total = 0;
  int bad   = 0;

  hex7seg_to_byte #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .d1(d1), .d0(d0),
    .a(a), .a_valid(a_valid), .a_ready(a_ready),
    .dp(dp), .seg_err(seg_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Encoder glyphs, bit 0 = seg a ... bit 6 = seg g, bit 7 = dp.
  function automatic logic [0:7] enc(input logic [3:0] n, input logic dpv);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1111110; 4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101; 4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011; 4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111; 4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111; 4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111; 4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110; 4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111; default: s = 7'b1000111;
    endcase
    enc = {s, dpv};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " a"}, a, 0);
    chk({nm, " a_valid"}, a_valid, 0);
    chk({nm, " dp"}, dp, 0);
    chk({nm, " seg_err"}, seg_err, 0);
    chk({nm, " overrun"}, overrun, 0);
  endtask

  typedef struct {
    logic [0:7] p1;
    logic [0:7] p0;
    int         exp_vld;   // a_valid cycles expected in the window
    int         exp_err;   // seg_err cycles expected in the window
    logic [7:0] exp_a;     // a at the end of the window
    logic [1:0] exp_dp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int vcnt, ecnt, first_k;
    logic saw53;
    logic [7:0] cap;

    vecs[0] = '{8'b1010101_0, 8'b1110000_0, 0, 1, 8'h12, 2'b00}; // invalid d1
    vecs[1] = '{8'b0000000_0, 8'b0000000_0, 0, 0, 8'h12, 2'b00}; // both blank
    vecs[2] = '{8'b0000000_0, 8'b1110000_0, 0, 1, 8'h12, 2'b00}; // one blank
    vecs[3] = '{8'b1001111_1, 8'b1111001_1, 1, 0, 8'hE3, 2'b11}; // E3, both dp
    vecs[4] = '{8'b1000111_0, 8'b0000001_0, 0, 1, 8'hE3, 2'b11}; // invalid d0
    vecs[5] = '{8'b1110000_1, 8'b1000111_0, 1, 0, 8'h7F, 2'b10}; // 7F, dp d1

    // Reset and first-byte latency.
    rst_n = 1'b0; a_ready = 1'b0;
    d1 = enc(4'h1, 1'b0); d0 = enc(4'h2, 1'b0);
    step(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(5);
    chk("lat a_valid@E0+4", a_valid, 0);
    step(1);
    chk("lat a_valid@E0+5", a_valid, 1);
    chk("lat a", a, 8'h12);
    step(3);
    chk("lat held a_valid", a_valid, 1);
    a_ready = 1'b1;
    step(1);
    chk("lat drop a_valid", a_valid, 0);

    // Table: invalid / blank / dp cases.
    for (int i = 0; i < 6; i++) begin
      d1 = vecs[i].p1; d0 = vecs[i].p0;
      vcnt = 0; ecnt = 0;
      for (int k = 0; k < 10; k++) begin
        step(1);
        vcnt += int'(a_valid);
        ecnt += int'(seg_err);
      end
      chk($sformatf("vec%0d valid cycles", i), vcnt, vecs[i].exp_vld);
      chk($sformatf("vec%0d seg_err cycles", i), ecnt, vecs[i].exp_err);
      chk($sformatf("vec%0d a", i), a, vecs[i].exp_a);
      chk($sformatf("vec%0d dp", i), dp, vecs[i].exp_dp);
    end

    // Sweep every byte value.
    for (int v = 0; v < 256; v++) begin
      d1 = enc(4'(v >> 4), 1'b0); d0 = enc(4'(v), 1'b0);
      vcnt = 0; ecnt = 0; cap = 8'h00;
      for (int k = 0; k < 10; k++) begin
        step(1);
        if (a_valid) begin vcnt++; cap = a; end
        ecnt += int'(seg_err);
      end
      chk($sformatf("sweep %02h count", v), vcnt, 1);
      chk($sformatf("sweep %02h a", v), cap, v);
      if (ecnt != 0) chk($sformatf("sweep %02h seg_err", v), ecnt, 0);
    end
    chk("sweep overrun", overrun, 0);

    // Glitch: 0x5A, d0 briefly 3, back to A.
    saw53 = 1'b0;
    d1 = enc(4'h5, 1'b0); d0 = enc(4'hA, 1'b0);
    step(2);
    d0 = enc(4'h3, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step(1);
      if (a_valid && a == 8'h53) saw53 = 1'b1;
    end
    d0 = enc(4'hA, 1'b0);
    first_k = -1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      if (a_valid && a == 8'h53) saw53 = 1'b1;
      if (a_valid && first_k < 0) begin first_k = k; cap = a; end
    end
    chk("glitch no 53", saw53, 0);
    chk("glitch emit edge", first_k, 6);
    chk("glitch a", cap, 8'h5A);

    // Overrun.
    a_ready = 1'b0;
    d1 = enc(4'h3, 1'b0); d0 = enc(4'hC, 1'b0);
    step(10);
    chk("ovr first a", a, 8'h3C);
    chk("ovr first valid", a_valid, 1);
    chk("ovr first flag", overrun, 0);
    d1 = enc(4'hA, 1'b0); d0 = enc(4'h5, 1'b0);
    step(10);
    chk("ovr a", a, 8'hA5);
    chk("ovr valid", a_valid, 1);
    chk("ovr flag", overrun, 1);
    a_ready = 1'b1;
    step(1);
    a_ready = 1'b0;
    chk("ovr drop valid", a_valid, 0);
    chk("ovr sticky", overrun, 1);
    step(2);
    chk("ovr sticky later", overrun, 1);

    // Asynchronous reset mid-settle with a byte pending.
    d1 = enc(4'h8, 1'b0); d0 = enc(4'h1, 1'b0);
    step(10);
    chk("rst pre valid", a_valid, 1);
    d1 = enc(4'h9, 1'b0); d0 = enc(4'h6, 1'b0);
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("rst async");
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("rst rel a_valid@E0+4", a_valid, 0);
    step(1);
    chk("rst rel a_valid@E0+5", a_valid, 1);
    chk("rst rel a", a, 8'h96);
    chk("rst rel overrun", overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
